// File: rtl/window_pkg.sv
// Shared types and helpers for the vertical column window generator.
package window_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    FILL0,
    FILL1,
    STREAM
  } state_e;

  // Counter width that never collapses to zero bits.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/column_window_gen_if.sv
// Pixel-in / column-out handshake bundle for column_window_gen.
interface column_window_gen_if
  import window_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic              in_valid;
  logic              in_ready;
  logic              in_sof;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_top;
  logic [DATA_W-1:0] out_mid;
  logic [DATA_W-1:0] out_bot;
  logic              out_eol;
  logic              out_eof;

  modport slave (
    input  in_valid, in_sof, in_data, out_ready,
    output in_ready, out_valid, out_top, out_mid, out_bot, out_eol, out_eof
  );

  modport master (
    output in_valid, in_sof, in_data, out_ready,
    input  in_ready, out_valid, out_top, out_mid, out_bot, out_eol, out_eof
  );
endinterface

// File: rtl/line_buffer_ram.sv
// Line buffer: one word per column, asynchronous read, synchronous write.
module line_buffer_ram
  import window_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int WIDTH = 16,
  parameter int AW    = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/column_window_gen.sv
// Turns a raster pixel stream into vertical 3-pixel columns (rows r-2, r-1, r).
module column_window_gen
  import window_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480
) (
  input logic                 clk,
  input logic                 rst_n,
  column_window_gen_if.slave  bus
);
  localparam int CW = cnt_w(IMG_W);
  localparam int RW = cnt_w(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  state_e            state_q, state_d, eff_state;
  logic [CW-1:0]     col_q, col_d, eff_col;
  logic [RW-1:0]     row_q, row_d, eff_row;
  logic              accept, emit, col_last, row_last;
  logic              out_valid_q, out_eol_q, out_eof_q;
  logic [DATA_W-1:0] out_top_q, out_mid_q, out_bot_q;
  logic [DATA_W-1:0] lb_a, lb_b;
  logic [2*DATA_W-1:0] rd_word;

  assign bus.in_ready = !out_valid_q | bus.out_ready;
  assign accept       = bus.in_valid & bus.in_ready;
  assign lb_b         = rd_word[2*DATA_W-1:DATA_W];
  assign lb_a         = rd_word[DATA_W-1:0];

  // Each column word holds {row r-2, row r-1}; one write shifts the pair down.
  line_buffer_ram #(
    .DEPTH (IMG_W),
    .WIDTH (2 * DATA_W),
    .AW    (CW)
  ) u_lb (
    .clk     (clk),
    .we_i    (accept),
    .addr_i  (eff_col),
    .wdata_i ({lb_a, bus.in_data}),
    .rdata_o (rd_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL0;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    // An accepted start-of-frame beat overrides whatever the counters say.
    eff_state = (accept & bus.in_sof) ? FILL0 : state_q;
    eff_col   = (accept & bus.in_sof) ? '0    : col_q;
    eff_row   = (accept & bus.in_sof) ? '0    : row_q;
    col_last  = (eff_col == COL_LAST);
    row_last  = (eff_row == ROW_LAST);
    emit      = accept & (eff_state == STREAM);
    if (accept) begin
      col_d   = col_last ? '0 : eff_col + 1'b1;
      row_d   = col_last ? (row_last ? '0 : eff_row + 1'b1) : eff_row;
      state_d = eff_state;
      unique case (eff_state)
        FILL0:   if (col_last) state_d = FILL1;
        FILL1:   if (col_last) state_d = STREAM;
        STREAM:  if (col_last && row_last) state_d = FILL0;
        default: state_d = FILL0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_top_q   <= '0;
      out_mid_q   <= '0;
      out_bot_q   <= '0;
      out_eol_q   <= 1'b0;
      out_eof_q   <= 1'b0;
    end else if (emit) begin
      out_valid_q <= 1'b1;
      out_top_q   <= lb_b;
      out_mid_q   <= lb_a;
      out_bot_q   <= bus.in_data;
      out_eol_q   <= col_last;
      out_eof_q   <= col_last & row_last;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_top   = out_top_q;
  assign bus.out_mid   = out_mid_q;
  assign bus.out_bot   = out_bot_q;
  assign bus.out_eol   = out_eol_q;
  assign bus.out_eof   = out_eof_q;
endmodule

// File: tb/tb_column_window_gen.sv
// Directed-vector and scoreboard bench for column_window_gen (4x3 image, 8-bit pixels).
module tb_column_window_gen;
  localparam int IMG_W = 4;
  localparam int IMG_H = 3;

  typedef struct {
    logic       vld;
    logic       sof;
    logic [7:0] dat;
    logic       ordy;
    logic       erdy;
    logic       evld;
    logic [7:0] etop;
    logic [7:0] emid;
    logic [7:0] ebot;
    logic       eeol;
    logic       eeof;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec  = 0;
  int   n_miss = 0;
  vec_t vq[$];
  logic [25:0] sbq[$];
  logic [7:0]  img [0:4][0:2][0:3];

  column_window_gen_if #(.DATA_W(8)) bus ();

  column_window_gen #(
    .DATA_W (8),
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s idx=%0d actual=%h required=%h", nm, idx, act, exp);
    end
  endtask

  function void add(input logic vld, input logic sof, input logic [7:0] dat, input logic ordy,
                    input logic erdy, input logic evld, input logic [7:0] t, input logic [7:0] m,
                    input logic [7:0] b, input logic eol, input logic eof);
    vec_t v;
    v.vld = vld; v.sof = sof; v.dat = dat; v.ordy = ordy; v.erdy = erdy; v.evld = evld;
    v.etop = t; v.emid = m; v.ebot = b; v.eeol = eol; v.eeof = eof;
    vq.push_back(v);
  endfunction

  // Standard pixel 16*r+c with free-flowing output; row 2 yields column (c, 0x10+c, 0x20+c).
  function void add_pix(input int r, input int c);
    add(1'b1, 1'b0, 8'(16 * r + c), 1'b1, 1'b1, r == 2, 8'(c), 8'(16 + c), 8'(32 + c),
        c == 3, c == 3);
  endfunction

  function void add_frame();
    for (int p = 0; p < IMG_W * IMG_H; p++) add_pix(p / IMG_W, p % IMG_W);
  endfunction

  task automatic run_vq();
    foreach (vq[i]) begin
      @(negedge clk);
      bus.in_valid  = vq[i].vld;
      bus.in_sof    = vq[i].sof;
      bus.in_data   = vq[i].dat;
      bus.out_ready = vq[i].ordy;
      #1;
      n_vec++;
      chk("in_ready", n_vec, {7'b0, bus.in_ready}, {7'b0, vq[i].erdy});
      @(posedge clk);
      #1;
      chk("out_valid", n_vec, {7'b0, bus.out_valid}, {7'b0, vq[i].evld});
      if (vq[i].evld) begin
        chk("out_top", n_vec, bus.out_top, vq[i].etop);
        chk("out_mid", n_vec, bus.out_mid, vq[i].emid);
        chk("out_bot", n_vec, bus.out_bot, vq[i].ebot);
        chk("out_eol", n_vec, {7'b0, bus.out_eol}, {7'b0, vq[i].eeol});
        chk("out_eof", n_vec, {7'b0, bus.out_eof}, {7'b0, vq[i].eeof});
      end
    end
    vq.delete();
  endtask

  initial begin
    int k, cyc, got, f, r, c;
    logic [25:0] exp_col, act_col;

    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    #12 rst_n = 1'b1;
    #1;
    n_vec++;
    chk("rst_out_valid", 0, {7'b0, bus.out_valid}, 8'h00);
    chk("rst_out_top",   0, bus.out_top, 8'h00);
    chk("rst_out_mid",   0, bus.out_mid, 8'h00);
    chk("rst_out_bot",   0, bus.out_bot, 8'h00);
    chk("rst_eol_eof",   0, {6'b0, bus.out_eol, bus.out_eof}, 8'h00);
    chk("rst_in_ready",  0, {7'b0, bus.in_ready}, 8'h01);

    // Two frames back to back, no bubbles.
    add_frame();
    add_frame();
    run_vq();

    // Backpressure during row 2: the first column is held while out_ready is low.
    for (int p = 0; p < 8; p++) add_pix(p / 4, p % 4);
    add(1, 0, 8'h20, 0, 1, 1, 8'h00, 8'h10, 8'h20, 0, 0);
    add(1, 0, 8'h21, 0, 0, 1, 8'h00, 8'h10, 8'h20, 0, 0);
    add(1, 0, 8'h21, 0, 0, 1, 8'h00, 8'h10, 8'h20, 0, 0);
    add(1, 0, 8'h21, 1, 0, 1, 8'h01, 8'h11, 8'h21, 0, 0);
    // in_ready is 1 here since out_ready=1; re-record with correct expectation.
    vq[vq.size() - 1].erdy = 1'b1;
    add_pix(2, 2);
    add_pix(2, 3);
    add(0, 0, 8'h00, 1, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0);
    run_vq();

    // Resync: sof at counter position (1,2) restarts the frame there.
    for (int cc = 0; cc < 4; cc++) add(1, 0, 8'(8'hA0 + cc), 1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 8'hB0, 1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 8'hB1, 1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 8'h00, 1, 1, 0, 0, 0, 0, 0, 0);
    for (int p = 1; p < 12; p++) add_pix(p / 4, p % 4);
    run_vq();

    // Asynchronous reset in the middle of row 2.
    for (int p = 0; p < 10; p++) add_pix(p / 4, p % 4);
    run_vq();
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    chk("arst_out_valid", n_vec, {7'b0, bus.out_valid}, 8'h00);
    chk("arst_out_top",   n_vec, bus.out_top, 8'h00);
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    add_frame();
    add(0, 0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 0);
    run_vq();

    // Random gaps over five frames against a scoreboard.
    for (int fi = 0; fi < 5; fi++)
      for (int ri = 0; ri < 3; ri++)
        for (int ci = 0; ci < 4; ci++) img[fi][ri][ci] = 8'($urandom_range(0, 255));
    k = 0; cyc = 0; got = 0;
    while ((k < 60 || sbq.size() > 0 || bus.out_valid) && cyc < 3000) begin
      @(negedge clk);
      f = k / 12; r = (k % 12) / 4; c = k % 4;
      bus.in_valid  = (k < 60) && ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.in_sof    = 1'b0;
      bus.in_data   = (k < 60) ? img[f][r][c] : 8'h00;
      #1;
      if (bus.out_valid && bus.out_ready) begin
        n_vec++;
        got++;
        act_col = {bus.out_top, bus.out_mid, bus.out_bot, bus.out_eol, bus.out_eof};
        if (sbq.size() == 0) begin
          n_miss++;
          $display("FAIL rnd_extra col=%0d actual=%h required=none", got, act_col);
        end else begin
          exp_col = sbq.pop_front();
          if (act_col !== exp_col) begin
            n_miss++;
            $display("FAIL rnd_col col=%0d actual=%h required=%h", got, act_col, exp_col);
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        if (r == 2)
          sbq.push_back({img[f][0][c], img[f][1][c], img[f][2][c], c == 3, c == 3});
        k++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    n_vec++;
    if (cyc >= 3000) begin
      n_miss++;
      $display("FAIL rnd_timeout cycles=%0d actual_pixels=%0d required=60", cyc, k);
    end
    chk("rnd_columns", 0, 8'(got), 8'd20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
